// File: rtl/spram_march_pkg.sv
// Shared types and constants for the single-port RAM march tester.
// No logic here: state encoding, read pipeline depth and the default phase-1 pattern.
package spram_march_pkg;

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DONE} march_state_t;

  localparam int RD_LAT = 2;
  localparam logic [3:0] DEF_PATTERN = 4'b1010;

endpackage

// File: rtl/spram_march_ctrl.sv
// March tester for a single-port RAM (write P, read P, write ~P, read ~P). A clean run takes 4*DEPTH+2 cycles.
// start is honoured only in IDLE/DONE. The RAM is driven every cycle and is never stalled.
import spram_march_pkg::*;

module spram_march_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] PATTERN = DATA_WIDTH'(DEF_PATTERN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  march_state_t state, nxt_state;

  // Stage 0 of the read delay line is mem_addr itself; rd_addr is stage 1.
  logic [RD_LAT-1:0]     rd_vld, nxt_rd_vld;
  logic [ADDR_WIDTH-1:0] rd_addr, nxt_rd_addr;

  logic                  nxt_we, nxt_busy, nxt_done, nxt_pass;
  logic [ADDR_WIDTH-1:0] nxt_addr, nxt_fail_addr;
  logic [DATA_WIDTH-1:0] nxt_din, nxt_fail_data, expected;
  logic                  last_addr, issue;

  always_comb begin
    nxt_state     = state;
    nxt_we        = mem_we;
    nxt_addr      = mem_addr;
    nxt_din       = mem_din;
    nxt_busy      = busy;
    nxt_done      = done;
    nxt_pass      = pass;
    nxt_fail_addr = fail_addr;
    nxt_fail_data = fail_data;
    nxt_rd_addr   = mem_addr;
    issue         = 1'b0;
    expected      = (state == RD1) ? ~PATTERN : PATTERN;
    last_addr     = (mem_addr == LAST_ADDR);

    case (state)
      IDLE, DONE: begin
        if (start) begin
          nxt_state     = WR0;
          nxt_we        = 1'b1;
          nxt_addr      = '0;
          nxt_din       = PATTERN;
          nxt_busy      = 1'b1;
          nxt_done      = 1'b0;
          nxt_pass      = 1'b0;
          nxt_fail_addr = '0;
          nxt_fail_data = '0;
        end
      end
      WR0, WR1: begin
        if (last_addr) begin
          nxt_state = (state == WR0) ? RD0 : RD1;
          nxt_we    = 1'b0;
          nxt_addr  = '0;
          issue     = 1'b1;
        end else begin
          nxt_addr = mem_addr + 1'b1;
        end
      end
      RD0, RD1: begin
        if (rd_vld[0] && !last_addr) begin
          nxt_addr = mem_addr + 1'b1;
          issue    = 1'b1;
        end
        if (rd_vld[RD_LAT-1]) begin
          if (mem_dout != expected) begin
            // First mismatch wins; reads still in flight are dropped.
            nxt_state     = DONE;
            nxt_we        = 1'b0;
            nxt_busy      = 1'b0;
            nxt_done      = 1'b1;
            nxt_pass      = 1'b0;
            nxt_fail_addr = rd_addr;
            nxt_fail_data = mem_dout;
          end else if (rd_addr == LAST_ADDR) begin
            if (state == RD0) begin
              nxt_state = WR1;
              nxt_we    = 1'b1;
              nxt_addr  = '0;
              nxt_din   = ~PATTERN;
            end else begin
              nxt_state = DONE;
              nxt_busy  = 1'b0;
              nxt_done  = 1'b1;
              nxt_pass  = 1'b1;
            end
          end
        end
      end
      default: nxt_state = IDLE;
    endcase

    nxt_rd_vld = (nxt_state inside {RD0, RD1}) ? {rd_vld[RD_LAT-2:0], issue} : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rd_vld    <= '0;
      rd_addr   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state     <= nxt_state;
      rd_vld    <= nxt_rd_vld;
      rd_addr   <= nxt_rd_addr;
      mem_we    <= nxt_we;
      mem_addr  <= nxt_addr;
      mem_din   <= nxt_din;
      busy      <= nxt_busy;
      done      <= nxt_done;
      pass      <= nxt_pass;
      fail_addr <= nxt_fail_addr;
      fail_data <= nxt_fail_data;
    end
  end

endmodule

// File: tb/tb_spram_march_ctrl.sv
// Bench for spram_march_ctrl: behavioural RAM with an injectable stuck-at fault on read,
// plus a phase-level model of the march that predicts result, completion cycle and write count.
module tb_spram_march_ctrl;

  localparam int D = 16;
  localparam logic [3:0] PAT = 4'hA;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       mem_we, busy, done, pass;
  logic [3:0] mem_addr, mem_din, ram_dout, fail_addr, fail_data;

  int checks = 0;
  int fails  = 0;

  logic [3:0] ram [D];
  int         wr_count = 0;
  logic [3:0] f_addr = '0, f_mask = '0, f_val = '0;

  spram_march_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .PATTERN(PAT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(ram_dout),
    .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] faulty(input logic [3:0] a, input logic [3:0] d);
    return (a == f_addr) ? ((d & ~f_mask) | (f_val & f_mask)) : d;
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_din;
      wr_count      <= wr_count + 1;
    end
    ram_dout <= faulty(mem_addr, ram[mem_addr]);
  end

  // March model: memory always holds the last phase's pattern; reads see the fault.
  task automatic model(output logic p, output logic [3:0] fa, output logic [3:0] fd,
                       output int lat, output int nwr);
    logic [3:0] pat, rd;
    p = 1'b1; fa = '0; fd = '0; lat = 4 * D + 2; nwr = 2 * D;
    for (int ph = 0; ph < 2; ph++) begin
      pat = (ph == 0) ? PAT : ~PAT;
      for (int k = 0; k < D; k++) begin
        rd = faulty(4'(k), pat);
        if (rd != pat) begin
          p = 1'b0; fa = 4'(k); fd = rd;
          lat = ((ph == 0) ? D + 2 : 3 * D + 3) + k;
          nwr = (ph + 1) * D;
          return;
        end
      end
    end
  endtask

  // Pulses start, then samples #1 after each edge until done (bounded).
  task automatic run_march(input int restart_at, output int lat, output int busy_cnt,
                           output bit to, output logic a_done, output logic a_pass,
                           output logic a_busy, output logic [3:0] a_fa, output logic [3:0] a_fd);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    a_done = done; a_pass = pass; a_busy = busy; a_fa = fail_addr; a_fd = fail_data;
    lat = 0; busy_cnt = 0; to = 1'b0;
    forever begin
      if (busy) busy_cnt++;
      if (done) break;
      if (lat >= 300) begin to = 1'b1; break; end
      start = (lat + 1 == restart_at);
      @(posedge clk); #1; start = 1'b0;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== 4'h0 || mem_din !== 4'h0) begin fails++; $display("FAIL reset_addr_din got %h/%h want 0/0", mem_addr, mem_din); end
    checks++; if ({busy, done, pass} !== 3'b000) begin fails++; $display("FAIL reset_status got %b want 000", {busy, done, pass}); end
    checks++; if (fail_addr !== 4'h0 || fail_data !== 4'h0) begin fails++; $display("FAIL reset_fail_info got %h/%h want 0/0", fail_addr, fail_data); end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL idle_no_start got busy=%b we=%b want 0/0", busy, mem_we); end
  endtask

  task automatic test_clean;
    int lat, bc, bad, w0; bit to; logic ad, ap, ab; logic [3:0] afa, afd;
    f_mask = '0; w0 = wr_count;
    run_march(0, lat, bc, to, ad, ap, ab, afa, afd);
    checks++; if (to) begin fails++; $display("FAIL clean_timeout got no done want done"); end
    checks++; if (ab !== 1'b1 || mem_we !== 1'b0) begin fails++; $display("FAIL clean_accept_busy got %b want 1", ab); end
    checks++; if (lat !== 4 * D + 2) begin fails++; $display("FAIL clean_latency got %0d want %0d", lat, 4 * D + 2); end
    checks++; if (bc !== 4 * D + 2) begin fails++; $display("FAIL clean_busy_cycles got %0d want %0d", bc, 4 * D + 2); end
    checks++; if (pass !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL clean_pass got pass=%b busy=%b want 1/0", pass, busy); end
    checks++; if (wr_count - w0 !== 2 * D) begin fails++; $display("FAIL clean_writes got %0d want %0d", wr_count - w0, 2 * D); end
    bad = 0;
    for (int k = 0; k < D; k++) if (ram[k] !== ~PAT) bad++;
    checks++; if (bad !== 0) begin fails++; $display("FAIL clean_ram_final got %0d bad words want 0", bad); end
  endtask

  task automatic test_stuck_bit;
    int lat, bc, w0, w1; bit to; logic ad, ap, ab; logic [3:0] afa, afd;
    f_addr = 4'd5; f_mask = 4'b0001; f_val = 4'b0000; w0 = wr_count;
    run_march(0, lat, bc, to, ad, ap, ab, afa, afd);
    checks++; if (to) begin fails++; $display("FAIL stuck_timeout got no done want done"); end
    checks++; if (lat !== 3 * D + 3 + 5) begin fails++; $display("FAIL stuck_latency got %0d want %0d", lat, 3 * D + 8); end
    checks++; if (pass !== 1'b0 || fail_addr !== 4'd5 || fail_data !== 4'h4) begin fails++; $display("FAIL stuck_result got pass=%b addr=%h data=%h want 0/5/4", pass, fail_addr, fail_data); end
    w1 = wr_count;
    checks++; if (w1 - w0 !== 2 * D) begin fails++; $display("FAIL stuck_writes got %0d want %0d", w1 - w0, 2 * D); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (wr_count !== w1 || mem_we !== 1'b0) begin fails++; $display("FAIL stuck_no_late_writes got %0d extra we=%b want 0/0", wr_count - w1, mem_we); end
    checks++; if (done !== 1'b1 || fail_addr !== 4'd5) begin fails++; $display("FAIL stuck_hold got done=%b addr=%h want 1/5", done, fail_addr); end
  endtask

  task automatic test_addr0_stuck;
    int lat, bc, w0; bit to; logic ad, ap, ab; logic [3:0] afa, afd;
    f_addr = 4'd0; f_mask = 4'hF; f_val = 4'h0; w0 = wr_count;
    run_march(0, lat, bc, to, ad, ap, ab, afa, afd);
    checks++; if (to || lat !== D + 2) begin fails++; $display("FAIL addr0_latency got %0d want %0d", lat, D + 2); end
    checks++; if (pass !== 1'b0 || fail_addr !== 4'd0 || fail_data !== 4'h0) begin fails++; $display("FAIL addr0_result got pass=%b addr=%h data=%h want 0/0/0", pass, fail_addr, fail_data); end
    checks++; if (wr_count - w0 !== D) begin fails++; $display("FAIL addr0_no_wr1 got %0d writes want %0d", wr_count - w0, D); end
  endtask

  task automatic test_start_while_busy;
    int lat, bc, w0; bit to; logic ad, ap, ab; logic [3:0] afa, afd;
    f_mask = '0; w0 = wr_count;
    run_march(20, lat, bc, to, ad, ap, ab, afa, afd);
    checks++; if (to || lat !== 4 * D + 2) begin fails++; $display("FAIL busy_start_latency got %0d want %0d", lat, 4 * D + 2); end
    checks++; if (pass !== 1'b1 || wr_count - w0 !== 2 * D) begin fails++; $display("FAIL busy_start_result got pass=%b writes=%0d want 1/%0d", pass, wr_count - w0, 2 * D); end
  endtask

  task automatic test_reset_mid;
    int lat, bc; bit to; logic ad, ap, ab; logic [3:0] afa, afd;
    f_mask = '0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    checks++; if (mem_we !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL midrst_pre got we=%b busy=%b want 1/1", mem_we, busy); end
    reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin fails++; $display("FAIL midrst_we_async got %b want 0", mem_we); end
    checks++; if ({busy, done, pass, mem_addr, mem_din, fail_addr, fail_data} !== '0) begin fails++; $display("FAIL midrst_outputs got busy=%b addr=%h din=%h want all 0", busy, mem_addr, mem_din); end
    @(negedge clk); reset = 1'b0;
    run_march(0, lat, bc, to, ad, ap, ab, afa, afd);
    checks++; if (to || lat !== 4 * D + 2 || pass !== 1'b1) begin fails++; $display("FAIL midrst_rerun got lat=%0d pass=%b want %0d/1", lat, pass, 4 * D + 2); end
  endtask

  task automatic test_restart_after_pass;
    int lat, bc; bit to; logic ad, ap, ab; logic [3:0] afa, afd;
    f_addr = 4'd9; f_mask = 4'b0100; f_val = 4'b0100;
    run_march(0, lat, bc, to, ad, ap, ab, afa, afd);
    f_mask = '0;
    run_march(0, lat, bc, to, ad, ap, ab, afa, afd);
    checks++; if ({ad, ap, ab} !== 3'b001 || afa !== 4'h0 || afd !== 4'h0) begin fails++; $display("FAIL restart_after_fail_clear got d/p/b=%b%b%b addr=%h data=%h want 001/0/0", ad, ap, ab, afa, afd); end
    checks++; if (to || lat !== 4 * D + 2 || pass !== 1'b1) begin fails++; $display("FAIL restart_run1 got lat=%0d pass=%b want %0d/1", lat, pass, 4 * D + 2); end
    run_march(0, lat, bc, to, ad, ap, ab, afa, afd);
    checks++; if ({ad, ap, ab} !== 3'b001 || afa !== 4'h0 || afd !== 4'h0) begin fails++; $display("FAIL restart_after_pass_clear got d/p/b=%b%b%b want 001", ad, ap, ab); end
    checks++; if (to || lat !== 4 * D + 2 || pass !== 1'b1) begin fails++; $display("FAIL restart_run2 got lat=%0d pass=%b want %0d/1", lat, pass, 4 * D + 2); end
  endtask

  task automatic test_random;
    int lat, bc, w0, e_lat, e_nwr; bit to; logic ad, ap, ab, e_p; logic [3:0] afa, afd, e_fa, e_fd;
    for (int it = 0; it < 20; it++) begin
      f_addr = 4'($urandom_range(0, 15));
      f_mask = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      f_val  = 4'($urandom_range(0, 15));
      model(e_p, e_fa, e_fd, e_lat, e_nwr);
      w0 = wr_count;
      run_march(0, lat, bc, to, ad, ap, ab, afa, afd);
      checks++;
      if (to || lat !== e_lat || pass !== e_p || fail_addr !== e_fa || fail_data !== e_fd || wr_count - w0 !== e_nwr) begin
        fails++;
        $display("FAIL random_%0d got lat=%0d pass=%b addr=%h data=%h wr=%0d want %0d/%b/%h/%h/%0d",
                 it, lat, pass, fail_addr, fail_data, wr_count - w0, e_lat, e_p, e_fa, e_fd, e_nwr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuck_bit();
    test_addr0_stuck();
    test_start_while_busy();
    test_reset_mid();
    test_restart_after_pass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
